stream_seq_checker: RTL
=======================

Name: stream_seq_checker

Overview:
Synthesizable reader/verifier for the RX streamer client interface: the receiving counterpart to the counting-sequence generator that feeds the TX streamer. It drives rx_dreq with LFSR-based throttling, checks that received records form a +1 incrementing sequence, counts records, errors and loss events, and tracks min/max frame latency. It sits directly on rx_streamer's rx_* outputs in on-board link tests; status is exposed for a register bank.

Parameters:
g_data_width, 64, record width; must match the rx_streamer g_data_width
g_lfsr_seed, 16'hACE1, LFSR reset value; must be non-zero

Ports:
clk_sys_i  in  1  system clock; all logic in this domain
rst_i  in  1  asynchronous active-high reset
enable_i  in  1  checker enable
clear_i  in  1  synchronous clear of statistics
cfg_dreq_thr_i  in  8  dreq throttle threshold; 0 = never request, 255 = always request
rx_data_i  in  g_data_width  record from rx_streamer
rx_valid_i  in  1  record valid strobe
rx_lost_i  in  1  frame-loss pulse from rx_streamer
rx_latency_i  in  28  frame latency in clk_ref cycles
rx_latency_valid_i  in  1  latency sample strobe
rx_dreq_o  out  1  data request to rx_streamer
rec_count_o  out  32  records accepted
err_count_o  out  16  sequence mismatches
lost_count_o  out  16  rx_lost_i pulses
err_o  out  1  sticky error flag
first_err_got_o  out  g_data_width  received value at the first mismatch
first_err_exp_o  out  g_data_width  expected value at the first mismatch
lat_min_o  out  28  minimum latency seen
lat_max_o  out  28  maximum latency seen
lat_valid_o  out  1  at least one latency sample captured

Behaviour:
- Reset (async, rst_i=1):
  - all outputs 0
  - internal expected register 0
  - LFSR = g_lfsr_seed
  - state IDLE
- LFSR:
  - 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1
  - shifts every cycle when not in reset
- rx_dreq_o is registered. Each cycle:
  - enable_i=0 -> 0
  - cfg_dreq_thr_i=255 -> 1
  - otherwise -> (lfsr[7:0] < cfg_dreq_thr_i)
- A record is accepted on any cycle with rx_valid_i=1 and enable_i=1, independent of rx_dreq_o, because the streamer may deliver one cycle after dreq drops.
- States:
  - IDLE: records ignored. enable_i rising -> SYNC.
  - SYNC: on accept -> expected = rx_data_i+1; rec_count++; no compare; -> TRACK.
  - TRACK: on accept, rec_count++, then:
    - rx_data_i == expected -> expected = rx_data_i+1
    - mismatch -> err_count++ and err_o=1; expected = rx_data_i+1 (resync); on the first mismatch since reset/clear, capture first_err_got_o and first_err_exp_o.
  - Any state: enable_i=0 -> IDLE next cycle.
- Arithmetic:
  - expected wraps modulo 2^g_data_width, so all-ones followed by 0 is a match.
  - All counters saturate at all-ones.
- rx_lost_i=1 (enable_i=1):
  - lost_count++
  - state -> SYNC
  - if rx_valid_i is high in the same cycle, that record is processed as the SYNC record: counted, not compared.
- clear_i=1 (priority over everything except reset):
  - zero counters, err_o, first_err_*, lat_*
  - state -> SYNC if enable_i=1, else IDLE
  - a record arriving in the same cycle is discarded from statistics
  - LFSR and rx_dreq_o are unaffected
- Latency: on rx_latency_valid_i=1 with enable_i=1:
  - lat_valid_o=0 -> lat_min_o = lat_max_o = rx_latency_i, and lat_valid_o=1
  - otherwise lat_min_o = min(lat_min_o, rx_latency_i) and lat_max_o = max(lat_max_o, rx_latency_i)
- Status latency: all status outputs reflect an input event on the cycle after the triggering clock edge.
- Reset asserted mid-stream: immediate return to reset values; no partial counter updates.

Test Plan:
- Enable, thr=255, feed 0..99 with one valid every cycle -> rx_dreq_o=1 from the cycle after enable; rec_count=100, err_count=0, err_o=0.
- Feed 5,6,7,9,10 -> rec_count=5, err_count=1, first_err_got=9, first_err_exp=8, err_o=1; 10 accepted as a match.
- Feed 2^64-2, 2^64-1, 0, 1 -> err_count=0; checks wrap-around.
- Feed 3,4; pulse rx_lost_i together with valid data 20; then feed 21 -> lost_count=1, err_count=0, rec_count=4.
- Latency samples 500, 120, 900 -> lat_min=120, lat_max=900, lat_valid=1. Assert clear_i together with a valid record -> all statistics 0, that record is not counted.
- thr=0 -> rx_dreq_o stays 0. thr=128 over 10000 cycles -> dreq duty 45-55%. Assert rst_i mid-stream -> outputs 0 asynchronously.

Source files
------------

// File: rtl/stream_seq_checker.sv
// Receive-side checker for the counting-sequence link test: throttles rx_dreq with an LFSR,
// verifies +1 incrementing records, and keeps error/loss/latency statistics for a register bank.
module stream_seq_checker #(
    parameter int          g_data_width = 64,
    parameter logic [15:0] g_lfsr_seed  = 16'hACE1
) (
    input  logic                    clk_sys_i,
    input  logic                    rst_i,
    input  logic                    enable_i,
    input  logic                    clear_i,
    input  logic [7:0]              cfg_dreq_thr_i,
    input  logic [g_data_width-1:0] rx_data_i,
    input  logic                    rx_valid_i,
    input  logic                    rx_lost_i,
    input  logic [27:0]             rx_latency_i,
    input  logic                    rx_latency_valid_i,
    output logic                    rx_dreq_o,
    output logic [31:0]             rec_count_o,
    output logic [15:0]             err_count_o,
    output logic [15:0]             lost_count_o,
    output logic                    err_o,
    output logic [g_data_width-1:0] first_err_got_o,
    output logic [g_data_width-1:0] first_err_exp_o,
    output logic [27:0]             lat_min_o,
    output logic [27:0]             lat_max_o,
    output logic                    lat_valid_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_SYNC, ST_TRACK} state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [15:0]             r_lfsr;
    logic [15:0]             w_lfsr_nxt;
    logic                    w_dreq_nxt;
    logic                    r_dreq;
    logic [g_data_width-1:0] r_expected;
    logic [g_data_width-1:0] w_data_inc;
    logic                    w_accept;
    logic                    w_mismatch;
    logic [31:0]             r_rec_count;
    logic [15:0]             r_err_count;
    logic [15:0]             r_lost_count;
    logic                    r_err;
    logic [g_data_width-1:0] r_first_got;
    logic [g_data_width-1:0] r_first_exp;
    logic [27:0]             r_lat_min;
    logic [27:0]             r_lat_max;
    logic                    r_lat_valid;

    // Galois right-shift form of x^16+x^14+x^13+x^11+1.
    assign w_lfsr_nxt = {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    assign w_dreq_nxt = enable_i && ((cfg_dreq_thr_i == 8'hFF) || (r_lfsr[7:0] < cfg_dreq_thr_i));

    assign w_data_inc = rx_data_i + g_data_width'(1);
    // A loss pulse turns the coincident record into a fresh sync point, even out of IDLE.
    assign w_accept   = enable_i && rx_valid_i && !clear_i && ((r_state != ST_IDLE) || rx_lost_i);
    assign w_mismatch = w_accept && !rx_lost_i && (r_state == ST_TRACK) && (rx_data_i != r_expected);

    always_comb begin
        w_state_nxt = r_state;
        if (clear_i) begin
            w_state_nxt = enable_i ? ST_SYNC : ST_IDLE;
        end else if (!enable_i) begin
            w_state_nxt = ST_IDLE;
        end else if (rx_lost_i) begin
            w_state_nxt = rx_valid_i ? ST_TRACK : ST_SYNC;
        end else begin
            case (r_state)
                ST_IDLE:  w_state_nxt = ST_SYNC;
                ST_SYNC:  w_state_nxt = rx_valid_i ? ST_TRACK : ST_SYNC;
                ST_TRACK: w_state_nxt = ST_TRACK;
                default:  w_state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk_sys_i or posedge rst_i) begin
        if (rst_i) begin
            r_lfsr       <= g_lfsr_seed;
            r_dreq       <= 1'b0;
            r_expected   <= '0;
            r_rec_count  <= '0;
            r_err_count  <= '0;
            r_lost_count <= '0;
            r_err        <= 1'b0;
            r_first_got  <= '0;
            r_first_exp  <= '0;
            r_lat_min    <= '0;
            r_lat_max    <= '0;
            r_lat_valid  <= 1'b0;
        end else begin
            r_lfsr <= w_lfsr_nxt;
            r_dreq <= w_dreq_nxt;
            if (clear_i) begin
                r_rec_count  <= '0;
                r_err_count  <= '0;
                r_lost_count <= '0;
                r_err        <= 1'b0;
                r_first_got  <= '0;
                r_first_exp  <= '0;
                r_lat_min    <= '0;
                r_lat_max    <= '0;
                r_lat_valid  <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_expected <= w_data_inc;
                    if (r_rec_count != '1) r_rec_count <= r_rec_count + 32'd1;
                end
                if (w_mismatch) begin
                    if (r_err_count != '1) r_err_count <= r_err_count + 16'd1;
                    r_err <= 1'b1;
                    if (!r_err) begin
                        r_first_got <= rx_data_i;
                        r_first_exp <= r_expected;
                    end
                end
                if (enable_i && rx_lost_i && (r_lost_count != '1)) begin
                    r_lost_count <= r_lost_count + 16'd1;
                end
                if (enable_i && rx_latency_valid_i) begin
                    r_lat_valid <= 1'b1;
                    if (!r_lat_valid || (rx_latency_i < r_lat_min)) r_lat_min <= rx_latency_i;
                    if (!r_lat_valid || (rx_latency_i > r_lat_max)) r_lat_max <= rx_latency_i;
                end
            end
        end
    end

    assign rx_dreq_o       = r_dreq;
    assign rec_count_o     = r_rec_count;
    assign err_count_o     = r_err_count;
    assign lost_count_o    = r_lost_count;
    assign err_o           = r_err;
    assign first_err_got_o = r_first_got;
    assign first_err_exp_o = r_first_exp;
    assign lat_min_o       = r_lat_min;
    assign lat_max_o       = r_lat_max;
    assign lat_valid_o     = r_lat_valid;

endmodule
